// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Debounces KEY_W raw, active-low push-button inputs. Each key passes through
// a 2-flop synchronizer and is then filtered by its own four-state machine
// and filter counter. The block produces a one-cycle press event and a clean
// pressed level for every key.
//
// Optional feature (compile-time macro KEY_LONG_PRESS_EN):
//   Adds a per-key hold counter and the key_long output. key_long pulses once
//   per press after the key has spent TIME_LONG cycles in DOWN. Time spent in
//   RELEASE_DB pauses the count. It does not clear it.
//
// Parameters:
//   KEY_W      number of keys
//   TIME_20MS  filter length in clk cycles
//   CNT_W      filter counter width, 2**CNT_W > TIME_20MS
//   TIME_LONG  long-press threshold in clk cycles (KEY_LONG_PRESS_EN only)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   key_in     raw key pins, active low, asynchronous to clk
//   key_flag   one-cycle pulse per key on each debounced press
//   key_state  debounced level per key, 1 = pressed
//   key_long   one-cycle long-press pulse per key (KEY_LONG_PRESS_EN only)
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int KEY_W     = 4,
  parameter int TIME_20MS = 100_000,
  parameter int CNT_W     = 17,
  parameter int TIME_LONG = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_flag,
  output logic [KEY_W-1:0] key_state
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic [KEY_W-1:0] key_long
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    DOWN       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIME_20MS - 1);

  // Synchronizer stages. Both stages reset to 1, the released level.
  logic [KEY_W-1:0] sync1_q, sync1_d;
  logic [KEY_W-1:0] sync2_q, sync2_d;

  state_e           state_q [KEY_W];
  state_e           state_d [KEY_W];
  logic [CNT_W-1:0] cnt_q   [KEY_W];
  logic [CNT_W-1:0] cnt_d   [KEY_W];

  logic [KEY_W-1:0] key_flag_q,  key_flag_d;
  logic [KEY_W-1:0] key_state_q, key_state_d;

`ifdef KEY_LONG_PRESS_EN
  // The hold counter runs one step past TIME_LONG-1 to TIME_LONG and then
  // parks there. That terminal value marks the pulse as already sent for
  // this press.
  localparam int              HOLD_W    = $clog2(TIME_LONG + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIME_LONG - 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(TIME_LONG);

  logic [HOLD_W-1:0] hold_q [KEY_W];
  logic [HOLD_W-1:0] hold_d [KEY_W];
  logic [KEY_W-1:0]  key_long_q, key_long_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic for all keys
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in this block first gets a default value. A
  // path that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    key_flag_d  = '0;
    key_state_d = '0;
`ifdef KEY_LONG_PRESS_EN
    key_long_d  = '0;
`endif

    for (int i = 0; i < KEY_W; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      unique case (state_q[i])
        IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_DB;
            cnt_d[i]   = '0;
          end
        end
        PRESS_DB: begin
          if (sync2_q[i]) begin
            // The press did not stay stable long enough, so it is a bounce.
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]    = DOWN;
            cnt_d[i]      = '0;
            key_flag_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        DOWN: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASE_DB;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_DB: begin
          if (!sync2_q[i]) begin
            // A glitch during a hold. Resume the press without a new flag.
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase

      // The level is registered from the next state, so it changes on the
      // same edge as the state transition.
      key_state_d[i] = (state_d[i] == DOWN) || (state_d[i] == RELEASE_DB);

`ifdef KEY_LONG_PRESS_EN
      hold_d[i] = hold_q[i];
      if (state_q[i] == PRESS_DB && state_d[i] == DOWN) begin
        // A fresh press starts timing from zero. A return from RELEASE_DB
        // keeps the count it already has.
        hold_d[i] = '0;
      end else if (state_q[i] == DOWN && hold_q[i] != HOLD_DONE) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        if (hold_q[i] == HOLD_LAST) begin
          key_long_d[i] = 1'b1;
        end
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever the order of the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      key_flag_q  <= '0;
      key_state_q <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_flag_q  <= key_flag_d;
      key_state_q <= key_state_d;
      for (int i = 0; i < KEY_W; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef KEY_LONG_PRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_long_q <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      key_long_q <= key_long_d;
      for (int i = 0; i < KEY_W; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign key_long = key_long_q;
`endif

  assign key_flag  = key_flag_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Directed testbench for key_debounce, with TIME_20MS=8, TIME_LONG=40 and
// KEY_W=4. A raw level that is first sampled at edge k must give a key_flag
// pulse in the cycle after edge k+10 (2 synchronizer edges + 8 filter
// edges). A release sampled at edge k must drop key_state after edge k+10.
// Outputs are sampled 1 time unit after each rising edge. Inputs change at
// that same point, so the next edge samples the new value.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_debounce;

  localparam int KEY_W     = 4;
  localparam int TIME_20MS = 8;
  localparam int CNT_W     = 4;
  localparam int TIME_LONG = 40;
  localparam int LAT       = 2 + TIME_20MS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_flag;
  logic [KEY_W-1:0] key_state;
`ifdef KEY_LONG_PRESS_EN
  logic [KEY_W-1:0] key_long;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [KEY_W-1:0] exp_flag;
  logic [KEY_W-1:0] exp_state;

  key_debounce #(
    .KEY_W    (KEY_W),
    .TIME_20MS(TIME_20MS),
    .CNT_W    (CNT_W),
    .TIME_LONG(TIME_LONG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state)
`ifdef KEY_LONG_PRESS_EN
    ,
    .key_long (key_long)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = '1;
    #12;
    n_checks++;
    if ({key_flag, key_state} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got flag=%b state=%b exp 0000/0000", key_flag, key_state);
    end
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_checks++;
      if ({key_flag, key_state} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_idle j=%0d got flag=%b state=%b exp 0000/0000", j, key_flag, key_state);
      end
    end
  endtask

  task automatic test_clean_press();
    // Press key 0 for 30 edges, then release it for 14 edges.
    for (int j = 0; j < 44; j++) begin
      key_in = (j < 30) ? 4'b1110 : 4'b1111;
      tick();
      exp_flag  = (j == LAT) ? 4'b0001 : 4'b0000;
      exp_state = (j >= LAT && j < 30 + LAT) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (key_flag !== exp_flag) begin
        n_fail++;
        $display("FAIL clean_flag j=%0d got %b exp %b", j, key_flag, exp_flag);
      end
      n_checks++;
      if (key_state !== exp_state) begin
        n_fail++;
        $display("FAIL clean_state j=%0d got %b exp %b", j, key_state, exp_state);
      end
    end
  endtask

  task automatic test_bounce_reject();
    // Key 1 is low for 3 edges and high for 3 edges, repeated for 30 edges.
    // It then stays high.
    for (int j = 0; j < 44; j++) begin
      key_in = ((j < 30) && ((j / 3) % 2 == 0)) ? 4'b1101 : 4'b1111;
      tick();
      n_checks++;
      if ({key_flag, key_state} !== 8'h00) begin
        n_fail++;
        $display("FAIL bounce j=%0d got flag=%b state=%b exp 0000/0000", j, key_flag, key_state);
      end
    end
  endtask

  task automatic test_release_glitch();
    int flags;
    flags = 0;
    // Key 2: low for 20 edges, high for 3, low until edge 32, then released.
    for (int j = 0; j < 48; j++) begin
      key_in = (j < 20 || (j >= 23 && j < 33)) ? 4'b1011 : 4'b1111;
      tick();
      if (key_flag[2]) flags++;
      exp_flag  = (j == LAT) ? 4'b0100 : 4'b0000;
      exp_state = (j >= LAT && j < 33 + LAT) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (key_flag !== exp_flag) begin
        n_fail++;
        $display("FAIL glitch_flag j=%0d got %b exp %b", j, key_flag, exp_flag);
      end
      n_checks++;
      if (key_state !== exp_state) begin
        n_fail++;
        $display("FAIL glitch_state j=%0d got %b exp %b", j, key_state, exp_state);
      end
    end
    n_checks++;
    if (flags != 1) begin
      n_fail++;
      $display("FAIL glitch_flag_count got %0d exp 1", flags);
    end
  endtask

  task automatic test_simultaneous();
    for (int j = 0; j < 30; j++) begin
      key_in = (j < 16) ? 4'b0000 : 4'b1111;
      tick();
      exp_flag  = (j == LAT) ? 4'b1111 : 4'b0000;
      exp_state = (j >= LAT && j < 16 + LAT) ? 4'b1111 : 4'b0000;
      n_checks++;
      if (key_flag !== exp_flag) begin
        n_fail++;
        $display("FAIL simul_flag j=%0d got %b exp %b", j, key_flag, exp_flag);
      end
      n_checks++;
      if (key_state !== exp_state) begin
        n_fail++;
        $display("FAIL simul_state j=%0d got %b exp %b", j, key_state, exp_state);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    // First, bring key 3 into DOWN.
    for (int j = 0; j < 14; j++) begin
      key_in = 4'b0111;
      tick();
      exp_flag  = (j == LAT) ? 4'b1000 : 4'b0000;
      exp_state = (j >= LAT) ? 4'b1000 : 4'b0000;
      n_checks++;
      if ({key_flag, key_state} !== {exp_flag, exp_state}) begin
        n_fail++;
        $display("FAIL rstmid_pre j=%0d got flag=%b state=%b exp %b/%b", j, key_flag, key_state, exp_flag, exp_state);
      end
    end
    // Assert reset between edges. The clear must be immediate.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({key_flag, key_state} !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_async got flag=%b state=%b exp 0000/0000", key_flag, key_state);
    end
    tick();
    tick();
    n_checks++;
    if ({key_flag, key_state} !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_hold got flag=%b state=%b exp 0000/0000", key_flag, key_state);
    end
    rst_n = 1'b1;
    // Key 3 is still held, so it must be debounced again from scratch.
    for (int j = 0; j < 30; j++) begin
      key_in = (j < 16) ? 4'b0111 : 4'b1111;
      tick();
      exp_flag  = (j == LAT) ? 4'b1000 : 4'b0000;
      exp_state = (j >= LAT && j < 16 + LAT) ? 4'b1000 : 4'b0000;
      n_checks++;
      if ({key_flag, key_state} !== {exp_flag, exp_state}) begin
        n_fail++;
        $display("FAIL rstmid_post j=%0d got flag=%b state=%b exp %b/%b", j, key_flag, key_state, exp_flag, exp_state);
      end
    end
  endtask

`ifdef KEY_LONG_PRESS_EN
  task automatic test_long_press();
    logic [KEY_W-1:0] exp_long;
    int               longs;
    longs = 0;
    // Hold key 0 for 100 edges. key_flag arrives after edge 10 and
    // key_long arrives 40 cycles later, after edge 50.
    for (int j = 0; j < 114; j++) begin
      key_in = (j < 100) ? 4'b1110 : 4'b1111;
      tick();
      if (key_long[0]) longs++;
      exp_long = (j == LAT + TIME_LONG) ? 4'b0001 : 4'b0000;
      exp_flag = (j == LAT) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (key_long !== exp_long) begin
        n_fail++;
        $display("FAIL long_pulse j=%0d got %b exp %b", j, key_long, exp_long);
      end
      n_checks++;
      if (key_flag !== exp_flag) begin
        n_fail++;
        $display("FAIL long_flag j=%0d got %b exp %b", j, key_flag, exp_flag);
      end
    end
    n_checks++;
    if (longs != 1) begin
      n_fail++;
      $display("FAIL long_count got %0d exp 1", longs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_press();
`ifdef KEY_LONG_PRESS_EN
    test_long_press();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
